// File: rtl/dbf_pkg.sv
// Shared definitions for the DBF receive-channel blocks.
// Contents: FSM state encoding for the zone sequencer, default geometry
// parameters (also used by the channel blocks), and a counter-width helper.
package dbf_pkg;

    // Default line geometry
    localparam int unsigned DBF_ADDR_WD    = 6;
    localparam int unsigned DBF_NUM_ZONES  = 32;
    localparam int unsigned DBF_ZONE_LEN   = 64;
    localparam int unsigned DBF_TX_CYC     = 16;
    localparam int unsigned DBF_SETTLE_CYC = 4;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_TX_ENC     = 3'd1;
    localparam logic [2:0] ST_SETTLE_ENC = 3'd2;
    localparam logic [2:0] ST_ACQ_ENC    = 3'd3;
    localparam logic [2:0] ST_DONE_ENC   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_TX     = ST_TX_ENC,
        ST_SETTLE = ST_SETTLE_ENC,
        ST_ACQ    = ST_ACQ_ENC,
        ST_DONE   = ST_DONE_ENC
    } dbf_state_t;

    // Bits needed for a counter running 0..n-1 (at least 1)
    function automatic int unsigned dbf_cnt_wd(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dbf_zone_counter.sv
// Sample counter plus zone counter for the acquisition window.
// Ports:
//   clk, rst_i        clock, asynchronous active-high reset
//   en_i              advance the sample counter this cycle
//   clr_i             clear both counters (wins over en_i)
//   zone_o            current zone (registered)
//   samp_wrap_c_o     sample counter is at ZONE_LEN-1 (combinational)
//   zone_last_c_o     zone counter is at NUM_ZONES-1 (combinational)
module dbf_zone_counter
    import dbf_pkg::*;
#(
    parameter int unsigned ADDR_WD   = DBF_ADDR_WD,
    parameter int unsigned NUM_ZONES = DBF_NUM_ZONES,
    parameter int unsigned ZONE_LEN  = DBF_ZONE_LEN
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               clr_i,
    output logic [ADDR_WD-1:0] zone_o,
    output logic               samp_wrap_c_o,
    output logic               zone_last_c_o
);

    localparam int unsigned SAMP_WD = dbf_cnt_wd(ZONE_LEN);

    logic [SAMP_WD-1:0] samp_q, samp_d;
    logic [ADDR_WD-1:0] zone_q, zone_d;

    assign samp_wrap_c_o = (samp_q == SAMP_WD'(ZONE_LEN - 1));
    assign zone_last_c_o = (zone_q == ADDR_WD'(NUM_ZONES - 1));
    assign zone_o        = zone_q;

    // Next count: zone only advances on a sample wrap and saturates at the last zone
    always_comb begin
        samp_d = samp_q;
        zone_d = zone_q;
        if (clr_i) begin
            samp_d = '0;
            zone_d = '0;
        end else if (en_i) begin
            if (samp_wrap_c_o) begin
                samp_d = '0;
                if (!zone_last_c_o) begin
                    zone_d = zone_q + ADDR_WD'(1);
                end
            end else begin
                samp_d = samp_q + SAMP_WD'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            samp_q <= '0;
            zone_q <= '0;
        end else begin
            samp_q <= samp_d;
            zone_q <= zone_d;
        end
    end

endmodule

// File: rtl/dbf_zone_sequencer.sv
// Per-line controller for the DBF receive channels: transmit window, zone-0
// LUT preload, acquisition window and dynamic-focus zone stepping.
// Ports:
//   clk           system clock
//   rst_n         asynchronous reset, ACTIVE-HIGH despite the name
//   line_trig     single-cycle request to fire one line
//   abort         synchronous abort of the current line
//   tx_en         transmit window
//   start         acquisition window
//   dbf_lut_addr  current zone LUT address
//   dbf_lut_we    one-cycle LUT load strobe
//   zone_idx      current zone (debug / apodisation)
//   busy          high in any state except IDLE
//   line_done     one-cycle pulse on line completion
//   overrun       sticky: line_trig seen while busy
module dbf_zone_sequencer
    import dbf_pkg::*;
#(
    parameter int unsigned ADDR_WD    = DBF_ADDR_WD,
    parameter int unsigned NUM_ZONES  = DBF_NUM_ZONES,
    parameter int unsigned ZONE_LEN   = DBF_ZONE_LEN,
    parameter int unsigned TX_CYC     = DBF_TX_CYC,
    parameter int unsigned SETTLE_CYC = DBF_SETTLE_CYC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_trig,
    input  logic               abort,
    output logic               tx_en,
    output logic               start,
    output logic [ADDR_WD-1:0] dbf_lut_addr,
    output logic               dbf_lut_we,
    output logic [ADDR_WD-1:0] zone_idx,
    output logic               busy,
    output logic               line_done,
    output logic               overrun
);

    localparam int unsigned PH_MAX = (TX_CYC > SETTLE_CYC) ? TX_CYC : SETTLE_CYC;
    localparam int unsigned PH_WD  = dbf_cnt_wd(PH_MAX);

    // Parameter sanity checks at elaboration
    if (ZONE_LEN < 2) begin : g_chk_zone_len
        $error("dbf_zone_sequencer: ZONE_LEN must be >= 2");
    end
    if (NUM_ZONES < 1 || TX_CYC < 1 || SETTLE_CYC < 1) begin : g_chk_nonzero
        $error("dbf_zone_sequencer: NUM_ZONES, TX_CYC and SETTLE_CYC must be >= 1");
    end
    if ((64'd1 << ADDR_WD) < 64'(NUM_ZONES)) begin : g_chk_addr_wd
        $error("dbf_zone_sequencer: ADDR_WD too small for NUM_ZONES");
    end

    dbf_state_t         state_q, state_d;
    logic [PH_WD-1:0]   ph_q, ph_d;
    logic               tx_en_q, tx_en_d;
    logic               start_q, start_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;

    logic               cnt_en_c;
    logic               cnt_clr_c;
    logic               samp_wrap_c;
    logic               zone_last_c;
    logic [ADDR_WD-1:0] zone_cnt;

    dbf_zone_counter #(
        .ADDR_WD   (ADDR_WD),
        .NUM_ZONES (NUM_ZONES),
        .ZONE_LEN  (ZONE_LEN)
    ) u_zone_counter (
        .clk           (clk),
        .rst_i         (rst_n),
        .en_i          (cnt_en_c),
        .clr_i         (cnt_clr_c),
        .zone_o        (zone_cnt),
        .samp_wrap_c_o (samp_wrap_c),
        .zone_last_c_o (zone_last_c)
    );

    // Next state; outputs are derived from the state being entered so they register with it
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        we_d      = 1'b0;
        overrun_d = overrun_q;
        cnt_en_c  = 1'b0;
        cnt_clr_c = 1'b1;

        // A trigger in any non-IDLE state (DONE included) is an overrun
        if (line_trig && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                ph_d = '0;
                if (line_trig && !abort) begin
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ph_q == PH_WD'(TX_CYC - 1)) begin
                    // zone counter is held clear here, so the preload hits address 0
                    state_d = ST_SETTLE;
                    ph_d    = '0;
                    we_d    = 1'b1;
                end else begin
                    ph_d = ph_q + PH_WD'(1);
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ph_q == PH_WD'(SETTLE_CYC - 1)) begin
                    state_d = ST_ACQ;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_WD'(1);
                end
            end
            ST_ACQ: begin
                cnt_clr_c = abort;
                cnt_en_c  = !abort;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (samp_wrap_c) begin
                    if (zone_last_c) begin
                        state_d = ST_DONE;
                    end else begin
                        // strobe lands in the same cycle the incremented address appears
                        we_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_en_d = (state_d == ST_TX);
        start_d = (state_d == ST_ACQ);
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            ph_q      <= '0;
            tx_en_q   <= 1'b0;
            start_q   <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            tx_en_q   <= tx_en_d;
            start_q   <= start_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign tx_en        = tx_en_q;
    assign start        = start_q;
    assign dbf_lut_we   = we_q;
    assign busy         = busy_q;
    assign line_done    = done_q;
    assign overrun      = overrun_q;
    assign dbf_lut_addr = zone_cnt;
    assign zone_idx     = zone_cnt;

endmodule

// File: tb/tb_dbf_zone_sequencer.sv
// Self-checking bench for dbf_zone_sequencer: default-parameter instance plus
// a small-parameter instance (NUM_ZONES=2, ZONE_LEN=2, TX_CYC=1, SETTLE_CYC=1).
module tb_dbf_zone_sequencer;

    localparam int MAXC = 2200;
    localparam int LINE_CYC = 2075;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       line_trig = 1'b0;
    logic       abort = 1'b0;
    logic       tx_en, start, we, busy, line_done, overrun;
    logic [5:0] addr, zone;

    logic       s_trig = 1'b0;
    logic       s_abort = 1'b0;
    logic       s_tx, s_start, s_we, s_busy, s_done, s_overrun;
    logic [1:0] s_addr, s_zone;

    always #5 clk = ~clk;

    dbf_zone_sequencer dut (
        .clk(clk), .rst_n(rst_n), .line_trig(line_trig), .abort(abort),
        .tx_en(tx_en), .start(start), .dbf_lut_addr(addr), .dbf_lut_we(we),
        .zone_idx(zone), .busy(busy), .line_done(line_done), .overrun(overrun)
    );

    dbf_zone_sequencer #(
        .ADDR_WD(2), .NUM_ZONES(2), .ZONE_LEN(2), .TX_CYC(1), .SETTLE_CYC(1)
    ) sdut (
        .clk(clk), .rst_n(rst_n), .line_trig(s_trig), .abort(s_abort),
        .tx_en(s_tx), .start(s_start), .dbf_lut_addr(s_addr), .dbf_lut_we(s_we),
        .zone_idx(s_zone), .busy(s_busy), .line_done(s_done), .overrun(s_overrun)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle trace of one line, index = cycles after the trigger cycle
    logic r_tx[MAXC], r_start[MAXC], r_we[MAXC], r_busy[MAXC], r_done[MAXC];
    int   r_addr[MAXC], r_zone[MAXC];

    int st_first_tx, st_last_tx, st_first_start, st_n_start, st_we_cnt, st_we_seq_bad;
    int st_done_cyc, st_done_cnt, st_overlap, st_b2b, st_zone_mis;

    task automatic run_line(input int ncyc);
        int exp_addr;
        line_trig = 1'b1;
        tick();
        line_trig = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            r_tx[c] = tx_en; r_start[c] = start; r_we[c] = we;
            r_busy[c] = busy; r_done[c] = line_done;
            r_addr[c] = int'(addr); r_zone[c] = int'(zone);
            tick();
        end
        st_first_tx = -1; st_last_tx = -1; st_first_start = -1; st_n_start = 0;
        st_we_cnt = 0; st_we_seq_bad = 0; st_done_cyc = -1; st_done_cnt = 0;
        st_overlap = 0; st_b2b = 0; st_zone_mis = 0; exp_addr = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (r_tx[c]) begin
                if (st_first_tx < 0) st_first_tx = c;
                st_last_tx = c;
            end
            if (r_start[c]) begin
                if (st_first_start < 0) st_first_start = c;
                st_n_start++;
            end
            if (r_we[c]) begin
                st_we_cnt++;
                if (r_addr[c] != exp_addr) st_we_seq_bad++;
                exp_addr++;
                if (c > 1 && r_we[c-1]) st_b2b++;
            end
            if (r_done[c]) begin
                st_done_cnt++;
                st_done_cyc = c;
            end
            if (r_tx[c] && r_start[c]) st_overlap++;
            if (r_addr[c] != r_zone[c]) st_zone_mis++;
        end
    endtask

    task automatic chk_line(input string tag);
        chk({tag, "_first_tx"},    st_first_tx,    1);
        chk({tag, "_last_tx"},     st_last_tx,     16);
        chk({tag, "_first_start"}, st_first_start, 21);
        chk({tag, "_n_start"},     st_n_start,     2048);
        chk({tag, "_we_cnt"},      st_we_cnt,      32);
        chk({tag, "_we_seq"},      st_we_seq_bad,  0);
        chk({tag, "_done_cyc"},    st_done_cyc,    2069);
        chk({tag, "_done_cnt"},    st_done_cnt,    1);
        chk({tag, "_overlap"},     st_overlap,     0);
        chk({tag, "_we_b2b"},      st_b2b,         0);
        chk({tag, "_zone_eq"},     st_zone_mis,    0);
    endtask

    typedef struct {
        int          cyc;
        logic [10:0] exp;   // {tx, start, we, busy, done, addr[5:0]}
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input int c, input logic t, input logic s, input logic w,
                                input logic b, input logic d, input int a);
        vec_t v;
        v.cyc = c;
        v.exp = {t, s, w, b, d, 6'(a)};
        return v;
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [9:0] m_tx, m_start, m_we, m_done, m_busy;
        logic [1:0] a2, a5;
        int         ndone;

        vt.push_back(mk(1,    1, 0, 0, 1, 0, 0));
        vt.push_back(mk(16,   1, 0, 0, 1, 0, 0));
        vt.push_back(mk(17,   0, 0, 1, 1, 0, 0));
        vt.push_back(mk(18,   0, 0, 0, 1, 0, 0));
        vt.push_back(mk(20,   0, 0, 0, 1, 0, 0));
        vt.push_back(mk(21,   0, 1, 0, 1, 0, 0));
        vt.push_back(mk(84,   0, 1, 0, 1, 0, 0));
        vt.push_back(mk(85,   0, 1, 1, 1, 0, 1));
        vt.push_back(mk(86,   0, 1, 0, 1, 0, 1));
        vt.push_back(mk(2004, 0, 1, 0, 1, 0, 30));
        vt.push_back(mk(2005, 0, 1, 1, 1, 0, 31));
        vt.push_back(mk(2068, 0, 1, 0, 1, 0, 31));
        vt.push_back(mk(2069, 0, 0, 0, 1, 1, 31));
        vt.push_back(mk(2070, 0, 0, 0, 0, 0, 0));

        // Reset state (while reset held)
        #23;
        chk("reset_main", 32'({tx_en, start, we, busy, line_done, overrun, addr, zone}), 0);
        chk("reset_small", 32'({s_tx, s_start, s_we, s_busy, s_done, s_overrun, s_addr, s_zone}), 0);
        #4 rst_n = 1'b0;
        tick();

        // Line 1: cycle-exact table plus whole-line properties
        run_line(LINE_CYC);
        foreach (vt[i]) begin
            int c;
            c = vt[i].cyc;
            chk($sformatf("line1_cyc%0d", c),
                32'({r_tx[c], r_start[c], r_we[c], r_busy[c], r_done[c], 6'(r_addr[c])}),
                32'(vt[i].exp));
        end
        chk_line("line1");
        chk("line1_overrun", 32'(overrun), 0);

        // Back-to-back: trig on the DONE cycle is an overrun, one cycle later is accepted
        line_trig = 1'b1;
        tick();
        line_trig = 1'b0;
        for (int i = 0; i < 2068; i++) tick();
        chk("b2b_done_pulse", 32'(line_done), 1);
        line_trig = 1'b1;
        tick();
        chk("b2b_on_done", 32'({overrun, tx_en, busy}), 32'(3'b100));
        tick();
        line_trig = 1'b0;
        chk("b2b_next_idle", 32'({overrun, tx_en, busy}), 32'(3'b111));

        // Abort at ACQ cycle 500 (zone 7)
        for (int i = 0; i < 520; i++) tick();
        chk("abort_pre", 32'({start, addr, zone}), 32'({1'b1, 6'd7, 6'd7}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_post", 32'({tx_en, start, we, busy, line_done, addr, zone}), 0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (line_done || busy) ndone++;
            tick();
        end
        chk("abort_no_done", 32'(ndone), 0);

        // Full normal line after the abort
        run_line(LINE_CYC);
        chk_line("line3");
        chk("line3_overrun", 32'(overrun), 1);

        // Asynchronous reset mid-TX, not aligned to a clock edge
        line_trig = 1'b1;
        tick();
        line_trig = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_pre_tx", 32'(tx_en), 1);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_async", 32'({tx_en, busy, overrun}), 0);
        #2 rst_n = 1'b0;
        tick();

        // abort + trig together in IDLE: trig ignored, overrun unchanged
        abort = 1'b1;
        line_trig = 1'b1;
        tick();
        abort = 1'b0;
        line_trig = 1'b0;
        chk("idle_abort_trig", 32'({busy, tx_en, overrun}), 0);

        run_line(LINE_CYC);
        chk_line("line4");

        // Small parameters; a trig mid-ACQ must not disturb the line
        chk("small_ovr_pre", 32'(s_overrun), 0);
        s_trig = 1'b1;
        tick();
        s_trig = 1'b0;
        m_tx = '0; m_start = '0; m_we = '0; m_done = '0; m_busy = '0;
        a2 = '1; a5 = '1;
        for (int c = 1; c <= 9; c++) begin
            m_tx[c] = s_tx; m_start[c] = s_start; m_we[c] = s_we;
            m_done[c] = s_done; m_busy[c] = s_busy;
            if (c == 2) a2 = s_addr;
            if (c == 5) a5 = s_addr;
            s_trig = (c == 4);
            tick();
        end
        s_trig = 1'b0;
        chk("small_tx",      32'(m_tx),    32'(10'b0000000010));
        chk("small_we",      32'(m_we),    32'(10'b0000100100));
        chk("small_start",   32'(m_start), 32'(10'b0001111000));
        chk("small_done",    32'(m_done),  32'(10'b0010000000));
        chk("small_busy",    32'(m_busy),  32'(10'b0011111110));
        chk("small_we_addr", 32'({a2, a5}), 32'(4'b0001));
        chk("small_overlap", 32'(m_tx & m_start), 0);
        chk("small_overrun", 32'(s_overrun), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbf_zone_sequencer.md
Name: dbf_zone_sequencer

Overview:
- Per-line controller for the DBF receive channels.
- On each line trigger it:
  - drives the transmit window (tx_en);
  - preloads the zone-0 coarse/fine delay LUT entry;
  - asserts start for the acquisition window;
  - steps dbf_lut_addr through the dynamic-focus zones, pulsing dbf_lut_we once at each zone boundary.
- One instance fans out to all dbf_chN channels.

Parameters:
- ADDR_WD, 6, width of dbf_lut_addr; must be at least log2(NUM_ZONES).
- NUM_ZONES, 32, focal zones per line.
- ZONE_LEN, 64, acquisition samples (clk cycles) per zone.
- TX_CYC, 16, cycles tx_en is held high per line.
- SETTLE_CYC, 4, cycles between tx_en fall and start rise; LUT zone-0 load happens here.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous, active-high: asserted when 1, despite the codebase port name.
- line_trig  in  1  single-cycle request to fire one line.
- abort  in  1  synchronous abort of the current line.
- tx_en  out  1  transmit window; channel coarse-delay input is valid only while tx_en=0.
- start  out  1  acquisition window to all channels.
- dbf_lut_addr  out  ADDR_WD  current zone LUT address.
- dbf_lut_we  out  1  one-cycle LUT load strobe.
- zone_idx  out  ADDR_WD  current zone, for debug and apodisation lookup.
- busy  out  1  high in any state except IDLE.
- line_done  out  1  one-cycle pulse on line completion.
- overrun  out  1  sticky; set when line_trig arrives while busy.

Behaviour:
- Reset values (all outputs): tx_en=0, start=0, dbf_lut_addr=0, dbf_lut_we=0, zone_idx=0, busy=0, line_done=0, overrun=0; FSM=IDLE; counters=0.
- All outputs are registered.
- States: IDLE, TX, SETTLE, ACQ, DONE.
- IDLE:
  - line_trig=1 -> TX on the next edge.
  - tx_en=1 and busy=1 starting the cycle after trig.
  - zone and address reset to 0.
- TX:
  - tx_en=1 for exactly TX_CYC cycles.
  - Then SETTLE; tx_en=0 from the first SETTLE cycle.
- SETTLE:
  - Lasts SETTLE_CYC cycles.
  - dbf_lut_we=1 in the first SETTLE cycle only, with dbf_lut_addr=0.
  - Then ACQ.
- ACQ:
  - start=1 every cycle in ACQ.
  - A sample counter runs 0..ZONE_LEN-1.
  - When the counter wraps and zone_idx<NUM_ZONES-1: zone_idx and dbf_lut_addr increment, and dbf_lut_we=1 in the same cycle the new address appears.
  - When the counter wraps with zone_idx=NUM_ZONES-1: -> DONE, and start drops that cycle.
  - ACQ length = NUM_ZONES*ZONE_LEN cycles exactly.
- DONE:
  - One cycle; line_done=1, busy=1.
  - Then IDLE: busy=0, zone_idx=0, dbf_lut_addr=0.
- Trigger-to-start latency = 1 + TX_CYC + SETTLE_CYC cycles.
- Line-to-line: line_trig is accepted in IDLE only.
  - A trig in the same cycle DONE -> IDLE counts as busy: sets overrun, not accepted.
  - A trig in the following IDLE cycle is accepted.
- overrun: sticky until reset. A trig while busy never restarts the line.
- abort:
  - In TX, SETTLE or ACQ: the next edge -> IDLE directly.
  - tx_en, start and dbf_lut_we drop to 0, zone and address clear.
  - No line_done pulse.
  - abort in IDLE or DONE has no effect.
  - abort and line_trig together in IDLE: abort wins, the trig is ignored, overrun unchanged.
- Reset asserted mid-line: all outputs go to reset values immediately (asynchronous); on release the FSM is in IDLE.
- dbf_lut_we never asserts in two consecutive cycles (ZONE_LEN>=2 required; elaboration check).
- tx_en and start never assert together.

Decomposition:
- Shared package dbf_pkg: state encoding localparams (IDLE=0..DONE=4), plus defaults for ADDR_WD, NUM_ZONES, ZONE_LEN, TX_CYC, SETTLE_CYC, which are also used by the channel blocks.
- One sub-module, dbf_zone_counter: sample counter plus zone counter with wrap/terminal-count outputs, enable and clear. The FSM lives in the top.

Test Plan:
- Reset then single trig, default params:
  - tx_en high for cycles 1..16 after trig.
  - dbf_lut_we at cycle 17 with addr 0.
  - start high cycles 21..2068 (2048 cycles).
  - line_done at cycle 2069; busy low at 2070.
- Zone stepping:
  - dbf_lut_we pulses at ACQ cycles 64,128,…,1984: 31 pulses with addr 1..31.
  - No pulse after zone 31.
  - zone_idx equals addr throughout.
- Back-to-back:
  - trig on the line_done cycle -> overrun=1, no new TX.
  - trig one cycle later -> new line starts; overrun stays 1.
- Abort at ACQ cycle 500 (zone 7):
  - next cycle start=0, addr=0, busy=0.
  - no line_done.
  - a following trig runs a full normal line.
- Async reset asserted mid-TX, not clock-aligned: tx_en falls without a clock edge; after release a trig gives the normal latency of 21 to start.
- Small params (NUM_ZONES=2, ZONE_LEN=2, TX_CYC=1, SETTLE_CYC=1): we pulses at SETTLE and at ACQ cycle 2 only; start lasts 4 cycles; tx_en/start never overlap.
